uart_tx_param: RTL and testbench
================================

UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10417, sets clock cycles per serial bit; legal range is 2 or more.
REQ-002 Parameter DATA_BITS, default 8, sets data bits per frame; legal range is 5 to 9.
REQ-003 Parameter PARITY, default 0, selects parity: 0 = none, 1 = odd, 2 = even.
REQ-004 Parameter STOP_BITS, default 1, sets stop bits per frame; legal values are 1 or 2.
REQ-005 Port clk, input, 1 bit, is the single clock; all logic SHALL be rising-edge triggered.
REQ-006 Port rst, input, 1 bit, is the synchronous, active-low reset (rst=0 at a clk edge resets the block).
REQ-007 Port tx_data, input, DATA_BITS bits, is the payload, sampled on acceptance only.
REQ-008 Port tx_valid, input, 1 bit, is the request to send tx_data.
REQ-009 Port tx_ready, output, 1 bit, means the block can accept a frame this cycle.
REQ-010 Port tx_busy, output, 1 bit, is high while a frame is on the line.
REQ-011 Port tx_done, output, 1 bit, is a one-cycle completion pulse.
REQ-012 Port txd, output, 1 bit, is the serial line; it is high when idle.
REQ-013 Illegal parameter values SHALL stop elaboration with an error.

Function
REQ-014 The state machine SHALL have states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY=0.
REQ-015 A frame SHALL be accepted on any cycle where tx_valid=1 and tx_ready=1; tx_data is latched into a shift register in that cycle.
REQ-016 tx_ready SHALL be 1 only in IDLE and SHALL fall in the cycle after acceptance.
REQ-017 tx_valid while tx_ready=0 SHALL be ignored, with no queuing; tx_data changes after acceptance SHALL NOT affect the frame in flight.
REQ-018 txd SHALL drive the start bit (0) beginning on the cycle after acceptance, giving 1-cycle latency.
REQ-019 Each bit SHALL be held for exactly CLKS_PER_BIT cycles, timed by a baud counter of width $clog2(CLKS_PER_BIT).
REQ-020 The baud counter SHALL be held at 0 in IDLE and SHALL restart at the beginning of each frame.
REQ-021 Data bits SHALL be sent LSB first: bit 0 to bit DATA_BITS-1.
REQ-022 The parity bit SHALL be the XOR of the latched data (even parity), or its inverse for odd parity.
REQ-023 The stop phase SHALL hold txd=1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-024 Frame length SHALL be (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
REQ-025 When the stop phase completes, the FSM SHALL enter IDLE, and tx_done=1 and tx_ready=1 SHALL assert in that same cycle for exactly one cycle.
REQ-026 If tx_valid=1 in the tx_done cycle, the next frame SHALL be accepted in that cycle; the only gap between frames is that one idle cycle with txd=1.
REQ-027 tx_busy SHALL equal (state != IDLE).
REQ-028 txd SHALL be driven from a register and be glitch-free.

Reset
REQ-029 While rst=0 at a clk edge, the block SHALL go to IDLE with txd=1, tx_ready=0, tx_busy=0, tx_done=0, baud counter 0 and shift register 0.
REQ-030 tx_ready SHALL rise on the first edge at which rst=1 is sampled.
REQ-031 Reset during a frame SHALL abort it: txd=1 from the next edge, no tx_done, and the partial frame is not resumed.

Verification
REQ-032 The bench SHALL cover the following directed scenarios, with CLKS_PER_BIT=4 unless stated otherwise:
- 8N1, send 0xA5 -> txd = 0,1,0,1,0,0,1,0,1 then 1, each held 4 cycles; tx_done after 40 cycles.
- 8E1, send 0x07 -> parity bit = 1; 8O2, send 0x07 -> parity bit = 0, stop held 8 cycles; frame 48 cycles.
- 7N1, tx_valid held high with 0x41 then 0x42 -> two back-to-back frames, 1 idle cycle between; tx_done pulses twice.
- tx_valid pulsed with 0x33 at cycle 10 of a frame carrying 0x55 -> 0x33 is ignored; tx_data changed to 0xFF mid-frame -> 0x55 is still sent.
- rst=0 during data bit 3 -> txd=1 next cycle, tx_done never asserts, tx_ready=1 the cycle after rst=1.
- CLKS_PER_BIT=2, 9N1, send 0x1FF -> frame of 22 cycles with correct bit timing.

Source files
------------

// File: rtl/uart_tx_param.sv
// Purpose : parameterised UART transmitter (start, DATA_BITS LSB first, optional parity, STOP_BITS).
// Latency : start bit appears on txd the cycle after acceptance; tx_done pulses with return to IDLE.
// Backpressure: tx_ready is high only in IDLE; tx_valid while not ready is dropped, never queued.
// Ports   : clk, rst (sync active-low), tx_data/tx_valid/tx_ready handshake,
//           tx_busy (frame in flight), tx_done (1-cycle completion pulse), txd (registered serial line).
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 txd
);

  // Elaboration-time parameter guards.
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_param: CLKS_PER_BIT must be 2 or more");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  // Guard keeps the width sane even when the illegal-value error fires.
  localparam int              CW        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   CNT_MAX   = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]      LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par;
  logic                 bit_tick;
  logic                 accept;
  logic                 txd_nxt;
  logic                 ready_nxt;
  logic                 done_nxt;

  assign bit_tick = (cnt == CNT_MAX);
  assign accept   = tx_valid && tx_ready;
  assign tx_busy  = (state != S_IDLE);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_START;
      end
      S_START: begin
        if (bit_tick) state_nxt = S_DATA;
      end
      S_DATA: begin
        if (bit_tick && bit_idx == LAST_DATA) begin
          state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (bit_tick) state_nxt = S_STOP;
      end
      S_STOP: begin
        if (bit_tick && bit_idx == LAST_STOP) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: output logic ----------------
  // Outputs are computed from the upcoming state and registered, so txd,
  // tx_ready and tx_done all change together on the edge that enters a state.
  always_comb begin
    txd_nxt   = 1'b1;
    ready_nxt = (state_nxt == S_IDLE);
    done_nxt  = (state == S_STOP) && (state_nxt == S_IDLE);
    case (state_nxt)
      S_IDLE:   txd_nxt = 1'b1;
      S_START:  txd_nxt = 1'b0;
      // On a bit boundary inside DATA the shift happens on this same edge,
      // so the next bit to drive is the one currently at position 1.
      S_DATA:   txd_nxt = (state == S_DATA && bit_tick) ? shreg[1] : shreg[0];
      S_PARITY: txd_nxt = par;
      S_STOP:   txd_nxt = 1'b1;
      default:  txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      txd      <= 1'b1;
      tx_ready <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      txd      <= txd_nxt;
      tx_ready <= ready_nxt;
      tx_done  <= done_nxt;
    end
  end

  // ---------------- Datapath ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par     <= 1'b0;
    end else begin
      // Baud counter sits at 0 in IDLE so every frame starts a fresh bit period.
      if (state == S_IDLE || bit_tick) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end

      // bit_idx counts data bits in DATA and stop bits in STOP.
      if (state != state_nxt) begin
        bit_idx <= '0;
      end else if (bit_tick && (state == S_DATA || state == S_STOP)) begin
        bit_idx <= bit_idx + 4'd1;
      end

      if (accept) begin
        shreg <= tx_data;
        // Parity is fixed at acceptance: even = XOR of data, odd = its inverse.
        par   <= (^tx_data) ^ (PARITY == 1);
      end else if (state == S_DATA && bit_tick) begin
        shreg <= shreg >> 1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
module tb_uart_tx_param;

  // Instances: 0 = 8N1, 1 = 8E1, 2 = 8O2, 3 = 7N1, 4 = 9N1 @ 2 clk/bit, 5 = 8N1 (reset abort)
  function automatic int cfg_cpb(int i);
    return (i == 4) ? 2 : 4;
  endfunction
  function automatic int cfg_db(int i);
    case (i)
      3:       return 7;
      4:       return 9;
      default: return 8;
    endcase
  endfunction
  function automatic int cfg_par(int i);
    case (i)
      1:       return 2;
      2:       return 1;
      default: return 0;
    endcase
  endfunction
  function automatic int cfg_sb(int i);
    return (i == 2) ? 2 : 1;
  endfunction

  typedef struct {
    int    inst;
    string bits;
    string name;
  } exp_t;

  logic       clk = 1'b0;
  logic [8:0] dat   [6];
  logic       vld   [6];
  logic       rst_n [6];
  logic       rdy   [6];
  logic       busy  [6];
  logic       done  [6];
  logic       txd   [6];

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input string act, input string exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %s, required %s", name, act, exp);
  endtask

  for (genvar g = 0; g < 6; g++) begin : g_dut
    localparam int CPB = cfg_cpb(g);
    localparam int DB  = cfg_db(g);

    uart_tx_param #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   (DB),
      .PARITY      (cfg_par(g)),
      .STOP_BITS   (cfg_sb(g))
    ) u_dut (
      .clk     (clk),
      .rst     (rst_n[g]),
      .tx_data (dat[g][DB-1:0]),
      .tx_valid(vld[g]),
      .tx_ready(rdy[g]),
      .tx_busy (busy[g]),
      .tx_done (done[g]),
      .txd     (txd[g])
    );

    // Monitor: a falling txd starts a frame; every cycle of every bit is
    // checked against the queued expectation, then the tx_done cycle.
    if (g < 5) begin : g_mon
      initial begin : mon
        exp_t  e;
        string got;
        int    nb;
        int    nbad;
        logic  bv;
        forever begin
          @(negedge clk);
          if (rst_n[g] === 1'b1 && txd[g] === 1'b0) begin
            if (sb.size() > 0) begin
              e = sb.pop_front();
            end else begin
              e.inst = -1;
              e.bits = "0";
              e.name = "unexpected_frame";
            end
            nb   = e.bits.len();
            got  = "";
            nbad = 0;
            for (int b = 0; b < nb; b++) begin
              bv = (e.bits[b] == 8'h31);
              for (int c = 0; c < CPB; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (c == 0) got = $sformatf("%s%b", got, txd[g]);
                if (txd[g] !== bv || busy[g] !== 1'b1 || done[g] !== 1'b0 || rdy[g] !== 1'b0)
                  nbad++;
              end
            end
            chk(nbad == 0 && e.inst == g, e.name,
                $sformatf("inst=%0d bits=%s bad_cycles=%0d", g, got, nbad),
                $sformatf("inst=%0d bits=%s bad_cycles=0", e.inst, e.bits));
            @(negedge clk);
            chk(done[g] === 1'b1 && rdy[g] === 1'b1 && busy[g] === 1'b0 && txd[g] === 1'b1,
                {e.name, "_done"},
                $sformatf("done=%b rdy=%b busy=%b txd=%b", done[g], rdy[g], busy[g], txd[g]),
                "done=1 rdy=1 busy=0 txd=1");
          end
        end
      end
    end
  end

  task automatic push(input int g, input string bits, input string nm);
    exp_t e;
    e.inst = g;
    e.bits = bits;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic wait_rdy(input int g, input string nm);
    int t;
    t = 0;
    while (rdy[g] !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (rdy[g] !== 1'b1) chk(1'b0, {nm, "_rdy_wait"}, "timeout", "tx_ready=1");
  endtask

  task automatic send(input int g, input logic [8:0] d, input string bits, input string nm);
    wait_rdy(g, nm);
    push(g, bits, nm);
    dat[g] = d;
    vld[g] = 1'b1;
    @(posedge clk);
    #1 vld[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int lim, input string nm);
    int t;
    t = 0;
    while (done[g] !== 1'b1 && t < lim) begin
      @(negedge clk);
      t++;
    end
    if (done[g] !== 1'b1) chk(1'b0, {nm, "_done_wait"}, "timeout", "tx_done=1");
    @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int nb;
    for (int i = 0; i < 6; i++) begin
      rst_n[i] = 1'b0;
      vld[i]   = 1'b0;
      dat[i]   = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      chk(txd[i] === 1'b1 && rdy[i] === 1'b0 && busy[i] === 1'b0 && done[i] === 1'b0,
          $sformatf("reset_state_%0d", i),
          $sformatf("txd=%b rdy=%b busy=%b done=%b", txd[i], rdy[i], busy[i], done[i]),
          "txd=1 rdy=0 busy=0 done=0");
      rst_n[i] = 1'b1;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++)
      chk(rdy[i] === 1'b1, $sformatf("rdy_after_rst_%0d", i), $sformatf("rdy=%b", rdy[i]), "rdy=1");

    // 8N1 0xA5: 0 10100101 1
    send(0, 9'h0A5, "0101001011", "8n1_a5");
    wait_done(0, 100, "8n1_a5");

    // 8E1 0x07: parity 1; 8O2 0x07: parity 0, two stop bits
    send(1, 9'h007, "01110000011", "8e1_07");
    wait_done(1, 100, "8e1_07");
    send(2, 9'h007, "011100000011", "8o2_07");
    wait_done(2, 100, "8o2_07");

    // 7N1 back-to-back: tx_valid held high across the done cycle
    wait_rdy(3, "7n1");
    push(3, "010000011", "7n1_41");
    push(3, "001000011", "7n1_42");
    dat[3] = 9'h041;
    vld[3] = 1'b1;
    @(posedge clk);
    #1 dat[3] = 9'h042;
    nb = 0;
    while (done[3] !== 1'b1 && nb < 100) begin
      @(negedge clk);
      nb++;
    end
    chk(done[3] === 1'b1 && txd[3] === 1'b1 && rdy[3] === 1'b1, "7n1_gap_idle",
        $sformatf("done=%b txd=%b rdy=%b", done[3], txd[3], rdy[3]), "done=1 txd=1 rdy=1");
    @(posedge clk);
    #1 vld[3] = 1'b0;
    @(negedge clk);
    chk(txd[3] === 1'b0 && busy[3] === 1'b1, "7n1_b2b_start",
        $sformatf("txd=%b busy=%b", txd[3], busy[3]), "txd=0 busy=1");
    wait_done(3, 100, "7n1_42");

    // 0x55 in flight: a 0x33 request mid-frame is dropped, data change ignored
    send(0, 9'h055, "0101010101", "8n1_55_ignore");
    repeat (9) @(negedge clk);
    chk(rdy[0] === 1'b0, "rdy_low_in_frame", $sformatf("rdy=%b", rdy[0]), "rdy=0");
    dat[0] = 9'h033;
    vld[0] = 1'b1;
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    dat[0] = 9'h0FF;
    wait_done(0, 100, "8n1_55_ignore");
    nb = 0;
    repeat (48) begin
      @(negedge clk);
      if (txd[0] !== 1'b1 || busy[0] !== 1'b0) nb++;
    end
    chk(nb == 0, "no_queued_frame", $sformatf("busy_cycles=%0d", nb), "busy_cycles=0");

    // Reset during data bit 3 (frame cycles 16..19) of 0xF7, whose bit 3 is 0
    wait_rdy(5, "rst_abort");
    dat[5] = 9'h0F7;
    vld[5] = 1'b1;
    @(posedge clk);
    #1 vld[5] = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    chk(busy[5] === 1'b1 && txd[5] === 1'b0, "rst_pre_bit3",
        $sformatf("busy=%b txd=%b", busy[5], txd[5]), "busy=1 txd=0");
    rst_n[5] = 1'b0;
    @(posedge clk);
    #1;
    chk(txd[5] === 1'b1 && rdy[5] === 1'b0 && busy[5] === 1'b0 && done[5] === 1'b0, "rst_abort_state",
        $sformatf("txd=%b rdy=%b busy=%b done=%b", txd[5], rdy[5], busy[5], done[5]),
        "txd=1 rdy=0 busy=0 done=0");
    rst_n[5] = 1'b1;
    @(posedge clk);
    #1;
    chk(rdy[5] === 1'b1, "rst_rdy_rise", $sformatf("rdy=%b", rdy[5]), "rdy=1");
    nb = 0;
    repeat (60) begin
      @(negedge clk);
      if (done[5] !== 1'b0 || txd[5] !== 1'b1 || busy[5] !== 1'b0) nb++;
    end
    chk(nb == 0, "rst_no_resume", $sformatf("bad_cycles=%0d", nb), "bad_cycles=0");

    // 9N1 at 2 clocks per bit: 22-cycle frame
    send(4, 9'h1FF, "01111111111", "9n1_1ff_cpb2");
    wait_done(4, 100, "9n1_1ff_cpb2");

    repeat (10) @(negedge clk);
    chk(sb.size() == 0, "sb_drained", $sformatf("pending=%0d", sb.size()), "pending=0");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
